// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : CPU load/store front end for a word-wide RAM. Handles byte,
//                halfword, word (and doubleword on 64-bit builds) accesses at
//                any byte alignment. Accesses that straddle a word boundary
//                are split into two RAM beats. Load data is extracted and
//                sign/zero-extended; store data and byte enables are shifted
//                into the correct lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [1:0]              cpu_size,
    input  logic                    cpu_store,
    input  logic                    cpu_unsigned,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_err,
    output logic                    ram_valid,
    input  logic                    ram_ready,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic                    ram_we,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic                    ram_rvalid,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int         NB     = DATA_WIDTH / 8;
    localparam int         LOG2NB = $clog2(NB);
    localparam logic [4:0] NB5    = 5'(NB);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        RSP0 = 3'd2,
        REQ1 = 3'd3,
        RSP1 = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [1:0]              size_q,     size_d;
    logic                    store_q,    store_d;
    logic                    unsigned_q, unsigned_d;
    logic                    err_q,      err_d;
    logic [DATA_WIDTH-1:0]   rdata0_q,   rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q,   rdata1_d;

    logic [LOG2NB-1:0]       off;
    logic [ADDR_WIDTH-1:0]   word0_addr;
    logic [ADDR_WIDTH-1:0]   word1_addr;
    logic [4:0]              nbytes;
    logic [4:0]              span;
    logic                    two_beat;
    logic [NB-1:0]           bmask;
    logic [DATA_WIDTH-1:0]   wsel;
    logic [2*DATA_WIDTH-1:0] lanes;
    logic [2*NB-1:0]         be2;
    logic [2*DATA_WIDTH-1:0] cat;
    logic [DATA_WIDTH-1:0]   ext;
    logic                    signbit;
    logic                    fill;
    int                      nbits;
    logic [DATA_WIDTH-1:0]   loaded;
    logic [4:0]              acc_bytes;
    logic                    accept;

    assign off        = addr_q[LOG2NB-1:0];
    assign word0_addr = {addr_q[ADDR_WIDTH-1:LOG2NB], {LOG2NB{1'b0}}};
    // Natural ADDR_WIDTH overflow gives the wrap at the top of the address space.
    assign word1_addr = word0_addr + ADDR_WIDTH'(NB);

    // Lane steering for stores and byte extraction/extension for loads.
    always_comb begin
        nbytes   = 5'd1 << size_q;
        span     = {{(5-LOG2NB){1'b0}}, off} + nbytes;
        two_beat = (span > NB5);
        for (int k = 0; k < NB; k++) begin
            bmask[k]        = (5'(k) < nbytes);
            wsel[8*k +: 8]  = bmask[k] ? wdata_q[8*k +: 8] : 8'h00;
        end
        lanes = {{DATA_WIDTH{1'b0}}, wsel} << {off, 3'b000};
        be2   = {{NB{1'b0}}, bmask} << off;
        cat   = {rdata1_q, rdata0_q};
        for (int k = 0; k < NB; k++) begin
            ext[8*k +: 8] = cat[8*(int'(off) + k) +: 8];
        end
        case (size_q)
            2'd0:    signbit = ext[7];
            2'd1:    signbit = ext[15];
            2'd2:    signbit = ext[31];
            default: signbit = ext[DATA_WIDTH-1];
        endcase
        fill  = signbit & ~unsigned_q;
        nbits = 8 << size_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            loaded[i] = (i < nbits) ? ext[i] : fill;
        end
    end

    // Next-state, request latching, beat data capture and output decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        store_d    = store_q;
        unsigned_d = unsigned_q;
        err_d      = err_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        // Gated by rst_n so cpu_ready is low for the whole reset period.
        cpu_ready  = rst_n && (state_q == IDLE);
        accept     = cpu_valid && cpu_ready;
        acc_bytes  = 5'd1 << cpu_size;

        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        cpu_err    = 1'b0;
        ram_valid  = 1'b0;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_be     = '0;
        ram_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    size_d     = cpu_size;
                    store_d    = cpu_store;
                    unsigned_d = cpu_unsigned;
                    rdata0_d   = '0;
                    rdata1_d   = '0;
                    // Wider than the bus cannot be served: report an error
                    // without touching the RAM.
                    err_d      = (acc_bytes > NB5);
                    state_d    = (acc_bytes > NB5) ? DONE : REQ0;
                end
            end
            REQ0: begin
                ram_valid = 1'b1;
                ram_addr  = word0_addr;
                ram_we    = store_q;
                ram_be    = be2[NB-1:0];
                ram_wdata = store_q ? lanes[DATA_WIDTH-1:0] : '0;
                if (ram_ready) begin
                    if (!store_q)      state_d = RSP0;
                    else if (two_beat) state_d = REQ1;
                    else               state_d = DONE;
                end
            end
            RSP0: begin
                if (ram_rvalid) begin
                    rdata0_d = ram_rdata;
                    state_d  = two_beat ? REQ1 : DONE;
                end
            end
            REQ1: begin
                ram_valid = 1'b1;
                ram_addr  = word1_addr;
                ram_we    = store_q;
                ram_be    = be2[2*NB-1:NB];
                ram_wdata = store_q ? lanes[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
                if (ram_ready) begin
                    state_d = store_q ? DONE : RSP1;
                end
            end
            RSP1: begin
                if (ram_rvalid) begin
                    rdata1_d = ram_rdata;
                    state_d  = DONE;
                end
            end
            DONE: begin
                cpu_rvalid = 1'b1;
                cpu_err    = err_q;
                cpu_rdata  = (err_q || store_q) ? '0 : loaded;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            store_q    <= store_d;
            unsigned_q <= unsigned_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit (32-bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_store;
    logic        cpu_unsigned;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        ram_valid;
    logic        ram_ready;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic        ram_rvalid;
    logic [31:0] ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_valid    (cpu_valid),
        .cpu_ready    (cpu_ready),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_size     (cpu_size),
        .cpu_store    (cpu_store),
        .cpu_unsigned (cpu_unsigned),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .cpu_err      (cpu_err),
        .ram_valid    (ram_valid),
        .ram_ready    (ram_ready),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_be       (ram_be),
        .ram_wdata    (ram_wdata),
        .ram_rvalid   (ram_rvalid),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present one request for one cycle; the block must be ready.
    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic st,
                         input logic un, input logic [31:0] wd);
        chk("issue_ready", {63'd0, cpu_ready}, 64'd1);
        cpu_valid    = 1'b1;
        cpu_addr     = a;
        cpu_size     = sz;
        cpu_store    = st;
        cpu_unsigned = un;
        cpu_wdata    = wd;
        step();
        cpu_valid    = 1'b0;
        cpu_wdata    = 32'h0;
    endtask

    // Read beat: check the request, handshake, return data one cycle later.
    task automatic rd_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
        chk({tag, "_valid"}, {63'd0, ram_valid}, 64'd1);
        chk({tag, "_addr"},  {32'd0, ram_addr}, {32'd0, a});
        chk({tag, "_be"},    {60'd0, ram_be}, {60'd0, be});
        chk({tag, "_we"},    {63'd0, ram_we}, 64'd0);
        chk({tag, "_busy"},  {63'd0, cpu_ready}, 64'd0);
        ram_ready = 1'b1;
        step();
        ram_ready  = 1'b0;
        chk({tag, "_novalid"}, {63'd0, ram_valid}, 64'd0);
        ram_rvalid = 1'b1;
        ram_rdata  = d;
        step();
        ram_rvalid = 1'b0;
        ram_rdata  = 32'h0;
    endtask

    // Write beat: check the request fields then handshake.
    task automatic wr_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
        chk({tag, "_valid"}, {63'd0, ram_valid}, 64'd1);
        chk({tag, "_addr"},  {32'd0, ram_addr}, {32'd0, a});
        chk({tag, "_be"},    {60'd0, ram_be}, {60'd0, be});
        chk({tag, "_we"},    {63'd0, ram_we}, 64'd1);
        chk({tag, "_wdata"}, {32'd0, ram_wdata}, {32'd0, wd});
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0;
    endtask

    // Completion cycle followed by return to idle.
    task automatic done(input string tag, input logic [31:0] rd, input logic er);
        chk({tag, "_rvalid"}, {63'd0, cpu_rvalid}, 64'd1);
        chk({tag, "_rdata"},  {32'd0, cpu_rdata}, {32'd0, rd});
        chk({tag, "_err"},    {63'd0, cpu_err}, {63'd0, er});
        chk({tag, "_ramv"},   {63'd0, ram_valid}, 64'd0);
        step();
        chk({tag, "_rvalid_off"}, {63'd0, cpu_rvalid}, 64'd0);
        chk({tag, "_rdata_off"},  {32'd0, cpu_rdata}, 64'd0);
        chk({tag, "_err_off"},    {63'd0, cpu_err}, 64'd0);
        chk({tag, "_ready"},      {63'd0, cpu_ready}, 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        cpu_valid    = 1'b0;
        cpu_addr     = 32'h0;
        cpu_wdata    = 32'h0;
        cpu_size     = 2'd0;
        cpu_store    = 1'b0;
        cpu_unsigned = 1'b0;
        ram_ready    = 1'b0;
        ram_rvalid   = 1'b0;
        ram_rdata    = 32'h0;

        // Reset state: everything low, including cpu_ready.
        step();
        step();
        chk("rst_ready",  {63'd0, cpu_ready}, 64'd0);
        chk("rst_ramv",   {63'd0, ram_valid}, 64'd0);
        chk("rst_rvalid", {63'd0, cpu_rvalid}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {63'd0, cpu_ready}, 64'd1);
        step();

        // Aligned word load.
        issue(32'h0000_0100, 2'd2, 1'b0, 1'b0, 32'h0);
        rd_beat("lw", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        done("lw", 32'hDEAD_BEEF, 1'b0);

        // Byte load at the top lane, signed then unsigned.
        issue(32'h0000_0103, 2'd0, 1'b0, 1'b0, 32'h0);
        rd_beat("lb", 32'h0000_0100, 4'b1000, 32'h8000_0000);
        done("lb", 32'hFFFF_FF80, 1'b0);
        issue(32'h0000_0103, 2'd0, 1'b0, 1'b1, 32'h0);
        rd_beat("lbu", 32'h0000_0100, 4'b1000, 32'h8000_0000);
        done("lbu", 32'h0000_0080, 1'b0);

        // Signed halfword, upper half of a word.
        issue(32'h0000_0102, 2'd1, 1'b0, 1'b0, 32'h0);
        rd_beat("lh", 32'h0000_0100, 4'b1100, 32'h9ABC_0000);
        done("lh", 32'hFFFF_9ABC, 1'b0);

        // Misaligned halfword store spanning two words.
        issue(32'h0000_0107, 2'd1, 1'b1, 1'b0, 32'h0000_BEEF);
        wr_beat("sh0", 32'h0000_0104, 4'b1000, 32'hEF00_0000);
        wr_beat("sh1", 32'h0000_0108, 4'b0001, 32'h0000_00BE);
        done("sh", 32'h0, 1'b0);

        // Misaligned word load spanning two words.
        issue(32'h0000_0102, 2'd2, 1'b0, 1'b0, 32'h0);
        rd_beat("lw2a", 32'h0000_0100, 4'b1100, 32'h1122_3344);
        rd_beat("lw2b", 32'h0000_0104, 4'b0011, 32'h5566_7788);
        done("lw2", 32'h7788_1122, 1'b0);

        // Two-beat load wrapping past the top of the address space.
        issue(32'hFFFF_FFFE, 2'd2, 1'b0, 1'b0, 32'h0);
        rd_beat("wrapa", 32'hFFFF_FFFC, 4'b1100, 32'hAABB_CCDD);
        rd_beat("wrapb", 32'h0000_0000, 4'b0011, 32'h1122_3344);
        done("wrap", 32'h3344_AABB, 1'b0);

        // Store held off by ram_ready=0: request must stay stable.
        issue(32'h0000_0200, 2'd2, 1'b1, 1'b0, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", {63'd0, ram_valid}, 64'd1);
            chk("stall_addr",  {32'd0, ram_addr}, 64'h200);
            chk("stall_be",    {60'd0, ram_be}, 64'hF);
            chk("stall_wdata", {32'd0, ram_wdata}, 64'hCAFE_F00D);
            chk("stall_ready", {63'd0, cpu_ready}, 64'd0);
            step();
        end
        wr_beat("stall", 32'h0000_0200, 4'b1111, 32'hCAFE_F00D);
        done("stall", 32'h0, 1'b0);

        // Oversized access: error, no RAM request.
        issue(32'h0000_0300, 2'd3, 1'b0, 1'b0, 32'h0);
        done("size3", 32'h0, 1'b1);

        // Reset while waiting for the second read beat.
        issue(32'h0000_0106, 2'd2, 1'b0, 1'b0, 32'h0);
        rd_beat("rsta", 32'h0000_0104, 4'b1100, 32'h0102_0304);
        chk("rstb_valid", {63'd0, ram_valid}, 64'd1);
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready",  {63'd0, cpu_ready}, 64'd0);
        chk("midrst_ramv",   {63'd0, ram_valid}, 64'd0);
        chk("midrst_addr",   {32'd0, ram_addr}, 64'd0);
        chk("midrst_rvalid", {63'd0, cpu_rvalid}, 64'd0);
        ram_rvalid = 1'b1;
        ram_rdata  = 32'h5555_5555;
        step();
        ram_rvalid = 1'b0;
        chk("midrst_rvalid2", {63'd0, cpu_rvalid}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_post_ready", {63'd0, cpu_ready}, 64'd1);
        step();
        chk("midrst_idle_rvalid", {63'd0, cpu_rvalid}, 64'd0);
        issue(32'h0000_0101, 2'd0, 1'b0, 1'b1, 32'h0);
        rd_beat("after", 32'h0000_0100, 4'b0010, 32'h0000_A500);
        done("after", 32'h0000_00A5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
